// File: rtl/io_bus_decoder_dtack.sv
// io_bus_decoder_dtack
// Clocked chip-select decoder for the 68k IO region. A bus cycle starts when
// AS_L is low and IO_Select_H is high. Address[15:4] is compared with NUM_CH
// 16-byte windows. A matched cycle gets a held enable, a one-clock strobe and
// DTACK_L after WAIT_CYCLES. An unmatched cycle gets Bus_Error_L after
// TIMEOUT_CYCLES. Every output is driven from a register.
module io_bus_decoder_dtack #(
   parameter int unsigned          NUM_CH         = 4,
   parameter logic [NUM_CH*12-1:0] BASE_ADDRS     = 48'h806_804_802_800,
   parameter int unsigned          WAIT_CYCLES    = 2,
   parameter int unsigned          TIMEOUT_CYCLES = 16
) (
   input  logic              Clk,
   input  logic              Reset_L,
   input  logic [31:0]       Address,
   input  logic              IO_Select_H,
   input  logic              AS_L,
   output logic [NUM_CH-1:0] IO_Enable_H,
   output logic [NUM_CH-1:0] IO_Strobe_H,
   output logic              DTACK_L,
   output logic              Bus_Error_L
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ACK,
      S_NOMAP,
      S_ERR
   } state_t;

   state_t            state, state_nxt;
   logic [7:0]        count, count_nxt;
   logic              armed, armed_nxt;
   logic [NUM_CH-1:0] hit;
   logic              hit_any;
   logic [NUM_CH-1:0] enable_nxt, strobe_nxt;
   logic              dtack_nxt, berr_nxt;

   // Only Address[15:4] takes part in decoding. The region itself is
   // qualified by IO_Select_H.
   logic              unused_addr_bits;
   assign unused_addr_bits = ^{Address[31:16], Address[3:0]};

   // Priority window match. The loop runs from the top index down, so the
   // lowest matching channel is the one that remains in the one-hot result.
   always_comb begin
      hit = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (Address[15:4] == BASE_ADDRS[12*i +: 12]) begin
            hit    = '0;
            hit[i] = 1'b1;
         end
      end
   end

   assign hit_any = |hit;

   // Next-state and next-output logic. The decode result is taken only at the
   // start edge. It is then held in the enable register, so later address
   // changes are ignored. The armed flag requires at least one IDLE edge with
   // AS_L high before a start is accepted. Because of this, a strobe never
   // fires into a bus cycle that was already in progress at reset or at abort.
   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      armed_nxt  = armed;
      enable_nxt = IO_Enable_H;
      strobe_nxt = '0;
      dtack_nxt  = DTACK_L;
      berr_nxt   = Bus_Error_L;
      case (state)
         S_IDLE: begin
            if (AS_L) begin
               armed_nxt = 1'b1;
            end else if (armed && IO_Select_H) begin
               armed_nxt = 1'b0;
               if (hit_any) begin
                  enable_nxt = hit;
                  strobe_nxt = hit;
                  count_nxt  = 8'(WAIT_CYCLES);
                  state_nxt  = S_WAIT;
               end else begin
                  count_nxt  = 8'(TIMEOUT_CYCLES - 1);
                  state_nxt  = S_NOMAP;
               end
            end
         end
         S_WAIT: begin
            if (AS_L) begin
               state_nxt  = S_IDLE;
               count_nxt  = '0;
               enable_nxt = '0;
            end else if (count == 8'd0) begin
               state_nxt  = S_ACK;
               dtack_nxt  = 1'b0;
            end else begin
               count_nxt  = count - 8'd1;
            end
         end
         S_ACK: begin
            if (AS_L) begin
               state_nxt  = S_IDLE;
               enable_nxt = '0;
               dtack_nxt  = 1'b1;
            end
         end
         S_NOMAP: begin
            if (AS_L) begin
               state_nxt = S_IDLE;
               count_nxt = '0;
            end else if (count == 8'd0) begin
               state_nxt = S_ERR;
               berr_nxt  = 1'b0;
            end else begin
               count_nxt = count - 8'd1;
            end
         end
         S_ERR: begin
            if (AS_L) begin
               state_nxt = S_IDLE;
               berr_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt  = S_IDLE;
            count_nxt  = '0;
            armed_nxt  = 1'b0;
            enable_nxt = '0;
            dtack_nxt  = 1'b1;
            berr_nxt   = 1'b1;
         end
      endcase
   end

   // State, counter and registered outputs. Reset takes priority over any
   // cycle that is in progress.
   always_ff @(posedge Clk) begin
      if (!Reset_L) begin
         state       <= S_IDLE;
         count       <= '0;
         armed       <= 1'b0;
         IO_Enable_H <= '0;
         IO_Strobe_H <= '0;
         DTACK_L     <= 1'b1;
         Bus_Error_L <= 1'b1;
      end else begin
         state       <= state_nxt;
         count       <= count_nxt;
         armed       <= armed_nxt;
         IO_Enable_H <= enable_nxt;
         IO_Strobe_H <= strobe_nxt;
         DTACK_L     <= dtack_nxt;
         Bus_Error_L <= berr_nxt;
      end
   end

endmodule

// File: tb/tb_io_bus_decoder_dtack.sv
// Testbench for io_bus_decoder_dtack. Four instances share the same bus. Each
// has its own parameter set: defaults; zero wait with a one-clock timeout;
// duplicate windows with maximum wait; a five-clock wait. Each transaction is
// compared edge by edge against a timeline model of start, match and latency.
module tb_io_bus_decoder_dtack;
   localparam int NI = 4;
   localparam logic [47:0] BA_STD = 48'h806_804_802_800;
   localparam logic [47:0] BA_DUP = 48'h806_804_804_800;
   localparam logic [9:0]  IDLE_OUT = 10'b0000_0000_11;

   logic        Clk = 1'b0;
   logic        Reset_L, IO_Select_H, AS_L;
   logic [31:0] Address;
   logic [3:0]  en [NI];
   logic [3:0]  st [NI];
   logic        dt [NI];
   logic        be [NI];

   int          W  [NI] = '{2, 0, 15, 5};
   int          T  [NI] = '{16, 1, 255, 8};
   logic [47:0] BA [NI] = '{BA_STD, BA_STD, BA_DUP, BA_STD};

   logic [9:0]  cap [NI][64];
   int          tests = 0;
   int          fails = 0;

   always #5 Clk = ~Clk;

   io_bus_decoder_dtack #(.NUM_CH(4), .BASE_ADDRS(BA_STD), .WAIT_CYCLES(2), .TIMEOUT_CYCLES(16)) u0 (
      .Clk(Clk), .Reset_L(Reset_L), .Address(Address), .IO_Select_H(IO_Select_H), .AS_L(AS_L),
      .IO_Enable_H(en[0]), .IO_Strobe_H(st[0]), .DTACK_L(dt[0]), .Bus_Error_L(be[0]));
   io_bus_decoder_dtack #(.NUM_CH(4), .BASE_ADDRS(BA_STD), .WAIT_CYCLES(0), .TIMEOUT_CYCLES(1)) u1 (
      .Clk(Clk), .Reset_L(Reset_L), .Address(Address), .IO_Select_H(IO_Select_H), .AS_L(AS_L),
      .IO_Enable_H(en[1]), .IO_Strobe_H(st[1]), .DTACK_L(dt[1]), .Bus_Error_L(be[1]));
   io_bus_decoder_dtack #(.NUM_CH(4), .BASE_ADDRS(BA_DUP), .WAIT_CYCLES(15), .TIMEOUT_CYCLES(255)) u2 (
      .Clk(Clk), .Reset_L(Reset_L), .Address(Address), .IO_Select_H(IO_Select_H), .AS_L(AS_L),
      .IO_Enable_H(en[2]), .IO_Strobe_H(st[2]), .DTACK_L(dt[2]), .Bus_Error_L(be[2]));
   io_bus_decoder_dtack #(.NUM_CH(4), .BASE_ADDRS(BA_STD), .WAIT_CYCLES(5), .TIMEOUT_CYCLES(8)) u3 (
      .Clk(Clk), .Reset_L(Reset_L), .Address(Address), .IO_Select_H(IO_Select_H), .AS_L(AS_L),
      .IO_Enable_H(en[3]), .IO_Strobe_H(st[3]), .DTACK_L(dt[3]), .Bus_Error_L(be[3]));

   // Returns the lowest channel whose window holds the address, or -1 if none.
   function automatic int match_ch(int p, logic [31:0] a);
      for (int i = 0; i < 4; i++)
         if (BA[p][12*i +: 12] == a[15:4]) return i;
      return -1;
   endfunction

   // Returns the expected {enable, strobe, dtack, berr} after edge N+k.
   // Start edge N is the one with AS_L low. Edge N+hold samples AS_L high.
   function automatic logic [9:0] exp_out(int p, logic [31:0] a, logic sel, int hold, int k);
      int         c;
      logic [3:0] oh, e, s;
      logic       d, b;
      c = sel ? match_ch(p, a) : -1;
      oh = (c >= 0) ? 4'(1 << c) : 4'b0000;
      e = 4'b0000; s = 4'b0000; d = 1'b1; b = 1'b1;
      if (sel && k < hold) begin
         if (c >= 0) begin
            e = oh;
            if (k == 0) s = oh;
            if (k >= 1 + W[p]) d = 1'b0;
         end else if (k >= T[p]) begin
            b = 1'b0;
         end
      end
      return {e, s, d, b};
   endfunction

   // Drives one bus cycle and records every instance's outputs after each
   // edge. Before the call, AS_L must be high and one IDLE edge must already
   // have passed. After the start edge, the address and select change to
   // a_mid and sel_mid.
   task automatic do_txn(input logic [31:0] a, input logic sel, input int hold,
                         input logic [31:0] a_mid, input logic sel_mid);
      Address = a; IO_Select_H = sel; AS_L = 1'b0;
      for (int k = 0; k <= hold + 1; k++) begin
         @(posedge Clk); #1;
         for (int p = 0; p < NI; p++) cap[p][k] = {en[p], st[p], dt[p], be[p]};
         if (k == 0) begin
            Address = a_mid;
            IO_Select_H = sel ? sel_mid : 1'b0;
         end
         if (k == hold - 1) AS_L = 1'b1;
      end
   endtask

   task automatic test_reset;
      logic [31:0] a;
      a = 32'h0040_8024;
      Reset_L = 1'b0; AS_L = 1'b0; IO_Select_H = 1'b1; Address = a;
      for (int n = 0; n < 3; n++) begin
         @(posedge Clk); #1;
         for (int p = 0; p < NI; p++) begin
            tests++;
            if ({en[p], st[p], dt[p], be[p]} !== IDLE_OUT) begin
               fails++;
               $display("FAIL reset_hold p=%0d n=%0d got %b want %b", p, n, {en[p], st[p], dt[p], be[p]}, IDLE_OUT);
            end
         end
      end
      Reset_L = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(posedge Clk); #1;
         for (int p = 0; p < NI; p++) begin
            tests++;
            if ({en[p], st[p], dt[p], be[p]} !== IDLE_OUT) begin
               fails++;
               $display("FAIL reset_no_start p=%0d n=%0d got %b want %b", p, n, {en[p], st[p], dt[p], be[p]}, IDLE_OUT);
            end
         end
         if (n == 2) AS_L = 1'b1;
      end
      do_txn(a, 1'b1, 6, a, 1'b1);
      for (int p = 0; p < NI; p++)
         for (int k = 0; k <= 7; k++) begin
            tests++;
            if (cap[p][k] !== exp_out(p, a, 1'b1, 6, k)) begin
               fails++;
               $display("FAIL reset_first_txn p=%0d k=%0d got %b want %b", p, k, cap[p][k], exp_out(p, a, 1'b1, 6, k));
            end
         end
      // Reset asserted in the middle of a cycle, with AS_L still low afterwards.
      AS_L = 1'b0; Address = a;
      repeat (3) @(posedge Clk);
      Reset_L = 1'b0;
      @(posedge Clk); #1;
      Reset_L = 1'b1;
      for (int n = 0; n < 2; n++) begin
         for (int p = 0; p < NI; p++) begin
            tests++;
            if ({en[p], st[p], dt[p], be[p]} !== IDLE_OUT) begin
               fails++;
               $display("FAIL reset_mid_cycle p=%0d n=%0d got %b want %b", p, n, {en[p], st[p], dt[p], be[p]}, IDLE_OUT);
            end
         end
         @(posedge Clk); #1;
      end
      AS_L = 1'b1;
      @(posedge Clk); #1;
   endtask

   task automatic test_mapped_read;
      logic [31:0] al [4];
      int          hl [4];
      al = '{32'h0040_8024, 32'h0040_8000, 32'h0040_8040, 32'h0040_8063};
      hl = '{10, 5, 20, 3};
      for (int t = 0; t < 4; t++) begin
         do_txn(al[t], 1'b1, hl[t], al[t], 1'b1);
         for (int p = 0; p < NI; p++)
            for (int k = 0; k <= hl[t] + 1; k++) begin
               tests++;
               if (cap[p][k] !== exp_out(p, al[t], 1'b1, hl[t], k)) begin
                  fails++;
                  $display("FAIL mapped_read t=%0d p=%0d k=%0d got %b want %b", t, p, k, cap[p][k], exp_out(p, al[t], 1'b1, hl[t], k));
               end
            end
      end
   endtask

   task automatic test_unmapped;
      logic [31:0] a;
      a = 32'h0040_80F0;
      do_txn(a, 1'b1, 30, a, 1'b1);
      for (int p = 0; p < NI; p++)
         for (int k = 0; k <= 31; k++) begin
            tests++;
            if (cap[p][k] !== exp_out(p, a, 1'b1, 30, k)) begin
               fails++;
               $display("FAIL unmapped p=%0d k=%0d got %b want %b", p, k, cap[p][k], exp_out(p, a, 1'b1, 30, k));
            end
         end
      // A mapped address without IO_Select_H must be ignored.
      a = 32'h0040_8024;
      do_txn(a, 1'b0, 6, a, 1'b0);
      for (int p = 0; p < NI; p++)
         for (int k = 0; k <= 7; k++) begin
            tests++;
            if (cap[p][k] !== exp_out(p, a, 1'b0, 6, k)) begin
               fails++;
               $display("FAIL no_select p=%0d k=%0d got %b want %b", p, k, cap[p][k], exp_out(p, a, 1'b0, 6, k));
            end
         end
   endtask

   task automatic test_address_change;
      logic [31:0] a;
      a = 32'h0040_8040;
      do_txn(a, 1'b1, 22, 32'h0040_8060, 1'b0);
      for (int p = 0; p < NI; p++)
         for (int k = 0; k <= 23; k++) begin
            tests++;
            if (cap[p][k] !== exp_out(p, a, 1'b1, 22, k)) begin
               fails++;
               $display("FAIL addr_change p=%0d k=%0d got %b want %b", p, k, cap[p][k], exp_out(p, a, 1'b1, 22, k));
            end
         end
   endtask

   task automatic test_abort;
      logic [31:0] al [3];
      int          hl [3];
      al = '{32'h0040_8024, 32'h0040_80F0, 32'h0040_8024};
      hl = '{2, 1, 10};
      for (int t = 0; t < 3; t++) begin
         do_txn(al[t], 1'b1, hl[t], al[t], 1'b1);
         for (int p = 0; p < NI; p++)
            for (int k = 0; k <= hl[t] + 1; k++) begin
               tests++;
               if (cap[p][k] !== exp_out(p, al[t], 1'b1, hl[t], k)) begin
                  fails++;
                  $display("FAIL abort t=%0d p=%0d k=%0d got %b want %b", t, p, k, cap[p][k], exp_out(p, al[t], 1'b1, hl[t], k));
               end
            end
      end
   endtask

   task automatic test_random;
      logic [31:0] a, am;
      logic        sel, selm;
      int          hold;
      for (int t = 0; t < 60; t++) begin
         a = $urandom;
         if ($urandom_range(3, 0) != 0) a[31:16] = 16'h0040;
         case ($urandom_range(5, 0))
            0: a[15:4] = 12'h800;
            1: a[15:4] = 12'h802;
            2: a[15:4] = 12'h804;
            3: a[15:4] = 12'h806;
            4: a[15:4] = 12'h80F;
            default: ;
         endcase
         am   = $urandom;
         sel  = ($urandom_range(4, 0) != 0);
         selm = 1'(($urandom_range(1, 0)));
         hold = $urandom_range(35, 1);
         do_txn(a, sel, hold, am, selm);
         for (int p = 0; p < NI; p++)
            for (int k = 0; k <= hold + 1; k++) begin
               tests++;
               if (cap[p][k] !== exp_out(p, a, sel, hold, k)) begin
                  fails++;
                  $display("FAIL random t=%0d a=%h sel=%0d hold=%0d p=%0d k=%0d got %b want %b",
                           t, a, sel, hold, p, k, cap[p][k], exp_out(p, a, sel, hold, k));
               end
            end
      end
   endtask

   initial begin
      Reset_L = 1'b0; AS_L = 1'b1; IO_Select_H = 1'b0; Address = '0;
      test_reset;
      test_mapped_read;
      test_unmapped;
      test_address_change;
      test_abort;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule
